spram_req_ctrl: RTL and testbench

Initiator-side controller for a single-port SRAM macro wrapper with active-low chip enable, write enable and byte-write enables. It converts a valid/ready request channel (read or byte-masked write) into SRAM port cycles. It tracks the one-cycle SRAM read latency and returns read data on a valid/ready response channel through a small response FIFO, so response backpressure never loses data. It sits between an engine's local-buffer access logic and a 512x32 single-port RAM wrapper.

---
 rtl/spram_req_ctrl.sv | 126 ++++++++++++
 tb/tb_spram_req_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_req_ctrl.sv
// spram_req_ctrl
// Initiator-side controller for a single-port SRAM wrapper (active-low CEB,
// WEB and byte-write enables). Converts a valid/ready request channel into
// SRAM port cycles and returns read data through a small response FIFO, so
// backpressure on the response channel never loses data.
//
// Optional feature macro: SPRAM_REQ_CTRL_WR_ACK_EN
//   defined   - every accepted write returns a zero response, in order with reads
//   undefined - writes return nothing and ignore response credit

module spram_req_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_ceb,
    output logic                  mem_web,
    output logic [ADDR_W-1:0]     mem_a,
    output logic [DATA_W-1:0]     mem_d,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_q
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic                rst_done;
    logic                rd_pend;
    logic                pend_ack;
    logic [DATA_W-1:0]   fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      used;
    logic                credit_ok;
    logic                rsp_gen;
    logic                acc;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   push_data;

    // Credit uses registered state only, so rsp_ready never reaches req_ready.
    assign used      = {1'b0, count} + {{CNT_W{1'b0}}, rd_pend};
    assign credit_ok = used < (CNT_W+1)'(RSP_DEPTH);

`ifdef SPRAM_REQ_CTRL_WR_ACK_EN
    assign rsp_gen   = 1'b1;
    assign req_ready = rst_done & credit_ok;
`else
    assign rsp_gen   = ~req_we;
    assign req_ready = rst_done & (credit_ok | req_we);
`endif

    assign acc = req_valid & req_ready;

    // The SRAM port idles (all strobes high) whenever nothing is accepted.
    assign mem_ceb = ~acc;
    assign mem_web = ~(acc & req_we);
    assign mem_a   = req_addr;
    assign mem_d   = req_wdata;
    assign mem_be  = ~(req_be & {BE_W{acc & req_we}});

    assign push      = rd_pend;
    assign pop       = rsp_valid & rsp_ready;
    assign push_data = pend_ack ? '0 : mem_q;
    assign rsp_valid = (count != '0);
    assign rsp_rdata = fifo_mem[rd_ptr];

    // Gate request acceptance until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Remember that the SRAM returns (or owes an ack for) a response next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            pend_ack <= 1'b0;
        end else begin
            rd_pend  <= acc & rsp_gen;
            pend_ack <= acc & rsp_gen & req_we;
        end
    end

    // Response FIFO: capture the SRAM output one cycle after the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_req_ctrl.sv
// tb_spram_req_ctrl
// Scoreboard bench for spram_req_ctrl with a behavioural 512x32 SRAM model.
// Honours SPRAM_REQ_CTRL_WR_ACK_EN for the expected response stream.

`timescale 1ns/1ps

module tb_spram_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        mem_ceb;
    logic        mem_web;
    logic [8:0]  mem_a;
    logic [31:0] mem_d;
    logic [3:0]  mem_be;
    logic [31:0] mem_q;

    logic [31:0] sram [512];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int last_pop_cyc = 0;
    int pop_count = 0;
    int stall_count = 0;
    logic [3:0] last_be;
    logic [31:0] exp_q [$];

`ifdef SPRAM_REQ_CTRL_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    spram_req_ctrl #(.ADDR_W(9), .DATA_W(32), .RSP_DEPTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_ceb   (mem_ceb),
        .mem_web   (mem_web),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_be    (mem_be),
        .mem_q     (mem_q)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: active-low enables, one-cycle read latency.
    always @(posedge clk) begin
        if (!mem_ceb) begin
            if (!mem_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (!mem_be[b]) sram[mem_a][b*8 +: 8] <= mem_d[b*8 +: 8];
                end
            end else begin
                mem_q <= sram[mem_a];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard whenever a response leaves the DUT.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            pop_count++;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", rsp_rdata, 32'hxxxx_xxxx);
            end else begin
                checkOutput("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Drive one request (called at posedge+1) and wait for its handshake.
    task automatic applyStimulus(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [31:0] exp_rd);
        int waits = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
            stall_count++;
            if (waits > 200) begin
                failNow("req_handshake");
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        last_be = mem_be;
        hs_cyc  = cyc;
        if (!we) exp_q.push_back(exp_rd);
        else if (WR_ACK) exp_q.push_back(32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic idleBus();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
    endtask

    task automatic drainWait();
        int n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                failNow("drain");
                exp_q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case anything wedges the simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        int p0;
        int last_hs;
        logic seen_ready;
        logic [31:0] d;

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 9'h0;
        req_wdata = 32'h0;
        req_be = 4'hF;

        // Reset state with a write request presented
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_mem_ceb", {31'h0, mem_ceb}, 32'h1);
        checkOutput("rst_mem_web", {31'h0, mem_web}, 32'h1);
        checkOutput("rst_mem_be", {28'h0, mem_be}, 32'hF);

        // Reset release: cycle 0 not ready, cycle 1 ready
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_we = 1'b0;
        @(negedge clk);
        checkOutput("rel_cyc0_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("rel_cyc0_ceb", {31'h0, mem_ceb}, 32'h1);
        @(posedge clk);
        #1;
        idleBus();
        @(negedge clk);
        checkOutput("rel_cyc1_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Write then masked write then read
        applyStimulus(1'b1, 9'h005, 32'hA5A5_5A5A, 4'b1111, 32'h0);
        checkOutput("wr1_mem_be", {28'h0, last_be}, 32'h0);
        applyStimulus(1'b1, 9'h005, 32'hFFFF_FFFF, 4'b0010, 32'h0);
        checkOutput("wr2_mem_be", {28'h0, last_be}, 32'hD);
        applyStimulus(1'b0, 9'h005, 32'h0, 4'h0, 32'hA5A5_FF5A);
        last_hs = hs_cyc;
        idleBus();
        drainWait();
        checkOutput("rd_latency", last_pop_cyc, last_hs + 2);

        // Write with no strobes changes nothing
        applyStimulus(1'b1, 9'h005, 32'h0000_0000, 4'b0000, 32'h0);
        checkOutput("wr0_mem_be", {28'h0, last_be}, 32'hF);
        applyStimulus(1'b0, 9'h005, 32'h0, 4'h0, 32'hA5A5_FF5A);
        idleBus();
        drainWait();

        // Prefill 64 words, then stream them back
        for (int i = 0; i < 64; i++) begin
            d = {16'hC0DE, 8'(i), ~8'(i)};
            applyStimulus(1'b1, 9'(9'h040 + i), d, 4'hF, 32'h0);
        end
        idleBus();
        drainWait();
        stall_count = 0;
        p0 = pop_count;
        for (int i = 0; i < 64; i++) begin
            d = {16'hC0DE, 8'(i), ~8'(i)};
            applyStimulus(1'b0, 9'(9'h040 + i), 32'h0, 4'h0, d);
        end
        last_hs = hs_cyc;
        idleBus();
        drainWait();
        checkOutput("stream_stalls", stall_count, 0);
        checkOutput("stream_count", pop_count - p0, 64);
        checkOutput("stream_last_lat", last_pop_cyc, last_hs + 2);

        // Backpressure: only three reads fit
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 9'h040, 32'h0, 4'h0, 32'hC0DE_00FF);
        applyStimulus(1'b0, 9'h041, 32'h0, 4'h0, 32'hC0DE_01FE);
        applyStimulus(1'b0, 9'h042, 32'h0, 4'h0, 32'hC0DE_02FD);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 9'h043;
        seen_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_ready = seen_ready | req_ready;
            @(posedge clk);
            #1;
        end
        checkOutput("bp_blocked", {31'h0, seen_ready}, 32'h0);
        checkOutput("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 9'h043, 32'h0, 4'h0, 32'hC0DE_03FC);
        idleBus();
        drainWait();

        // Write, read, write: response count depends on write acks
        p0 = pop_count;
        applyStimulus(1'b1, 9'h020, 32'hDEAD_BEEF, 4'hF, 32'h0);
        applyStimulus(1'b0, 9'h020, 32'h0, 4'h0, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 9'h021, 32'h1234_5678, 4'hF, 32'h0);
        idleBus();
        drainWait();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("wrack_rsp_count", pop_count - p0, WR_ACK ? 3 : 1);

        // Mid-operation reset with 2 queued and 1 pending
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 9'h040, 32'h0, 4'h0, 32'hC0DE_00FF);
        applyStimulus(1'b0, 9'h041, 32'h0, 4'h0, 32'hC0DE_01FE);
        applyStimulus(1'b0, 9'h042, 32'h0, 4'h0, 32'hC0DE_02FD);
        req_addr = 9'h043;
        #2;
        checkOutput("pre_rst_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("mid_rst_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("mid_rst_ceb", {31'h0, mem_ceb}, 32'h1);
        idleBus();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        p0 = pop_count;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("post_rst_stale", pop_count - p0, 0);
        @(posedge clk);
        #1;

        // Recovery read after reset
        applyStimulus(1'b0, 9'h07F, 32'h0, 4'h0, 32'hC0DE_3FC0);
        idleBus();
        drainWait();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
